// File: rtl/sevenseg_dec_mux.sv
// sevenseg_dec_mux
//   Multiplexed seven-segment driver that shows a signed or unsigned binary
//   value as decimal across NDIG digits. Digit 0 is the rightmost digit.
//   Binary-to-BCD conversion is sequential (double dabble, DATA_W cycles).
//   The display has leading-zero blanking, a floating minus sign and an
//   all-'E' overflow pattern.
//
// Ports
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   data   in   [DATA_W-1:0] value to display
//   load   in   capture strobe, accepted only while busy=0
//   busy   out  conversion in progress (DATA_W+1 cycles after accept)
//   ovf    out  last committed value did not fit
//   seg    out  [6:0] segments, active-low, {g,f,e,d,c,b,a}
//   an     out  [NDIG-1:0] digit enables, active-low, one-hot-zero
//   dp     out  decimal point, held off (1)
module sevenseg_dec_mux #(
  parameter int NDIG   = 4,
  parameter int DATA_W = 8,
  parameter int SIGNED = 1,
  parameter int CNTMAX = 65000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  output logic              busy,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              dp
);

  localparam int CNT_W = (CNTMAX < 1) ? 1 : $clog2(CNTMAX + 1);
  localparam int IDX_W = $clog2(NDIG);
  localparam int BCD_W = 4 * NDIG;
  localparam int BIT_W = $clog2(DATA_W + 1);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned k = 0; k < n; k++) begin
      r = r * 10;
    end
    return r;
  endfunction

  // Largest magnitudes that fit: all digits for positive values, one digit
  // fewer for negative values because the minus sign needs a position.
  localparam int unsigned LIM_POS = pow10(NDIG) - 1;
  localparam int unsigned LIM_NEG = pow10(NDIG - 1) - 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } state_t;

  // Refresh scan
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NDIG-1:0]  an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  // Conversion engine
  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;

  // Committed display
  logic [NDIG-1:0][6:0] dig_q, dig_d;
  logic                 ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(CNTMAX)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end
    // an and seg both follow the next index so they switch together.
    an_d        = '1;
    an_d[idx_d] = 1'b0;
    seg_d       = dig_q[idx_d];
  end

  always_comb begin
    logic              sign_c;
    logic [DATA_W-1:0] mag_c;
    logic [BCD_W-1:0]  bcd_adj;
    logic              ovf_c;
    int unsigned       msd;

    state_d  = state_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    shreg_d  = shreg_q;
    bcd_d    = bcd_q;
    bitcnt_d = bitcnt_q;
    dig_d    = dig_q;
    ovf_d    = ovf_q;

    sign_c  = (SIGNED != 0) && data[DATA_W-1];
    mag_c   = sign_c ? (~data + 1'b1) : data;
    bcd_adj = bcd_q;
    ovf_c   = 1'b0;
    msd     = 0;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          sign_d   = sign_c;
          mag_d    = mag_c;
          shreg_d  = mag_c;
          bcd_d    = '0;
          bitcnt_d = '0;
          state_d  = S_CONV;
        end
      end

      S_CONV: begin
        for (int unsigned i = 0; i < NDIG; i++) begin
          if (bcd_adj[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
          end
        end
        {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == BIT_W'(DATA_W - 1)) begin
          state_d = S_COMMIT;
        end
      end

      S_COMMIT: begin
        ovf_c = (!sign_q && (32'(mag_q) > LIM_POS)) ||
                ( sign_q && (32'(mag_q) > LIM_NEG));
        // Highest nonzero digit; stays 0 for value 0 so digit 0 always shows.
        for (int unsigned i = 0; i < NDIG; i++) begin
          if (bcd_q[4*i +: 4] != 4'd0) begin
            msd = i;
          end
        end
        for (int unsigned i = 0; i < NDIG; i++) begin
          if (ovf_c) begin
            dig_d[i] = SEG_E;
          end else if (i <= msd) begin
            dig_d[i] = seg_of(bcd_q[4*i +: 4]);
          end else if (sign_q && (i == msd + 1)) begin
            dig_d[i] = SEG_MINUS;
          end else begin
            dig_d[i] = SEG_BLANK;
          end
        end
        ovf_d   = ovf_c;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      an_q     <= {{(NDIG-1){1'b1}}, 1'b0};
      seg_q    <= SEG_BLANK;
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      shreg_q  <= '0;
      bcd_q    <= '0;
      bitcnt_q <= '0;
      dig_q    <= {NDIG{SEG_BLANK}};
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      state_q  <= state_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      shreg_q  <= shreg_d;
      bcd_q    <= bcd_d;
      bitcnt_q <= bitcnt_d;
      dig_q    <= dig_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign ovf  = ovf_q;
  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_sevenseg_dec_mux.sv
// Scoreboard bench for sevenseg_dec_mux. Three builds share clk/rst/data/load:
//   0: NDIG=4 signed, 1: NDIG=2 signed, 2: NDIG=4 unsigned (all CNTMAX=3).
// Stimulus pushes the expected display per build; a monitor per build pops
// on each busy falling edge, scans an/seg to rebuild the digits and checks.
module tb_sevenseg_dec_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       load;

  logic [3:0] an_a, an_c;
  logic [1:0] an_b;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       busy_a, busy_b, busy_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic       dp_a, dp_b, dp_c;

  logic [7:0] an_w   [3];
  logic [6:0] seg_w  [3];
  logic       busy_w [3];
  logic       ovf_w  [3];
  logic       dp_w   [3];

  always #5 clk = ~clk;

  sevenseg_dec_mux #(.NDIG(4), .DATA_W(8), .SIGNED(1), .CNTMAX(3)) u_4s (
    .clk(clk), .rst_n(rst_n), .data(data), .load(load), .busy(busy_a),
    .ovf(ovf_a), .seg(seg_a), .an(an_a), .dp(dp_a));
  sevenseg_dec_mux #(.NDIG(2), .DATA_W(8), .SIGNED(1), .CNTMAX(3)) u_2s (
    .clk(clk), .rst_n(rst_n), .data(data), .load(load), .busy(busy_b),
    .ovf(ovf_b), .seg(seg_b), .an(an_b), .dp(dp_b));
  sevenseg_dec_mux #(.NDIG(4), .DATA_W(8), .SIGNED(0), .CNTMAX(3)) u_4u (
    .clk(clk), .rst_n(rst_n), .data(data), .load(load), .busy(busy_c),
    .ovf(ovf_c), .seg(seg_c), .an(an_c), .dp(dp_c));

  // Unused upper enables padded with 1 (off)
  assign an_w[0] = {4'hF, an_a};
  assign an_w[1] = {6'h3F, an_b};
  assign an_w[2] = {4'hF, an_c};
  assign seg_w[0] = seg_a;  assign seg_w[1] = seg_b;  assign seg_w[2] = seg_c;
  assign busy_w[0] = busy_a; assign busy_w[1] = busy_b; assign busy_w[2] = busy_c;
  assign ovf_w[0] = ovf_a;  assign ovf_w[1] = ovf_b;  assign ovf_w[2] = ovf_c;
  assign dp_w[0] = dp_a;    assign dp_w[1] = dp_b;    assign dp_w[2] = dp_c;

  localparam logic [6:0] B = 7'h7F;
  localparam logic [6:0] M = 7'h3F;
  localparam logic [6:0] E = 7'h06;

  function automatic logic [6:0] sg(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [55:0] d4(input logic [6:0] a3, a2, a1, a0);
    return {28'd0, a3, a2, a1, a0};
  endfunction

  function automatic logic [55:0] d2(input logic [6:0] a1, a0);
    return {42'd0, a1, a0};
  endfunction

  typedef struct {
    logic [55:0] digs;
    logic        ovf;
    bit          chk_busy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [55:0] e0, input logic o0,
                          input logic [55:0] e1, input logic o1,
                          input logic [55:0] e2, input logic o2,
                          input bit chkb);
    exp_t e;
    e.chk_busy = chkb;
    e.digs = e0; e.ovf = o0; q0.push_back(e);
    e.digs = e1; e.ovf = o1; q1.push_back(e);
    e.digs = e2; e.ovf = o2; q2.push_back(e);
  endtask

  task automatic send(input logic [7:0] v);
    @(negedge clk);
    data = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (44) @(negedge clk);
  endtask

  task automatic check_output(input int g, input int unsigned blen);
    exp_t        e;
    bit          have;
    logic [55:0] cap;
    int          nd;
    logic [7:0]  an_exp;
    nd   = (g == 1) ? 2 : 4;
    have = 1'b0;
    case (g)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_output dut%0d: busy fell with no expected entry", g);
      return;
    end
    cap = '0;
    for (int i = 0; i < nd; i++) cap[i*7 +: 7] = 7'bx;
    repeat (2) @(negedge clk);
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < nd; i++) begin
        an_exp    = 8'hFF;
        an_exp[i] = 1'b0;
        if (an_w[g] == an_exp) cap[i*7 +: 7] = seg_w[g];
      end
    end
    chk($sformatf("digits dut%0d", g), {8'd0, cap}, {8'd0, e.digs});
    chk($sformatf("ovf dut%0d", g), {63'd0, ovf_w[g]}, {63'd0, e.ovf});
    if (e.chk_busy) chk($sformatf("busy_len dut%0d", g), 64'(blen), 64'd9);
  endtask

  task automatic monitor(input int g);
    int unsigned blen;
    logic        prev;
    blen = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_w[g] === 1'b1) blen++;
      if (prev === 1'b1 && busy_w[g] === 1'b0) begin
        check_output(g, blen);
        blen = 0;
      end
      prev = busy_w[g];
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a4, a2;
    int         t;
    rst_n = 1'b0;
    load  = 1'b0;
    data  = 8'd0;
    repeat (3) @(negedge clk);

    // Reset state, then refresh: each digit held CNTMAX+1 = 4 clocks
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_busy dut%0d", g), {63'd0, busy_w[g]}, 64'd0);
      chk($sformatf("rst_ovf dut%0d", g), {63'd0, ovf_w[g]}, 64'd0);
      chk($sformatf("dp dut%0d", g), {63'd0, dp_w[g]}, 64'd1);
    end
    t = 0;
    rst_n = 1'b1;
    while (t < 20) begin
      a4 = 8'hFF; a4[(t / 4) % 4] = 1'b0;
      a2 = 8'hFF; a2[(t / 4) % 2] = 1'b0;
      chk($sformatf("an4s t%0d", t), {56'd0, an_w[0]}, {56'd0, a4});
      chk($sformatf("an2s t%0d", t), {56'd0, an_w[1]}, {56'd0, a2});
      chk($sformatf("an4u t%0d", t), {56'd0, an_w[2]}, {56'd0, a4});
      chk($sformatf("seg_blank t%0d", t), {57'd0, seg_w[0]}, {57'd0, B});
      t++;
      @(negedge clk);
    end

    // 123
    push_exp(d4(B, sg(1), sg(2), sg(3)), 0, d2(E, E), 1,
             d4(B, sg(1), sg(2), sg(3)), 0, 1);
    send(8'd123);
    // -5 / 251
    push_exp(d4(B, B, M, sg(5)), 0, d2(M, sg(5)), 0,
             d4(B, sg(2), sg(5), sg(1)), 0, 1);
    send(8'hFB);
    // -128 / 128
    push_exp(d4(M, sg(1), sg(2), sg(8)), 0, d2(E, E), 1,
             d4(B, sg(1), sg(2), sg(8)), 0, 1);
    send(8'h80);
    // 0
    push_exp(d4(B, B, B, sg(0)), 0, d2(B, sg(0)), 0,
             d4(B, B, B, sg(0)), 0, 1);
    send(8'd0);
    // 100
    push_exp(d4(B, sg(1), sg(0), sg(0)), 0, d2(E, E), 1,
             d4(B, sg(1), sg(0), sg(0)), 0, 1);
    send(8'd100);
    // -9 / 247
    push_exp(d4(B, B, M, sg(9)), 0, d2(M, sg(9)), 0,
             d4(B, sg(2), sg(4), sg(7)), 0, 1);
    send(8'hF7);
    // -10 / 246
    push_exp(d4(B, M, sg(1), sg(0)), 0, d2(E, E), 1,
             d4(B, sg(2), sg(4), sg(6)), 0, 1);
    send(8'hF6);

    // Second load during CONV with a different value must be ignored
    push_exp(d4(B, sg(1), sg(2), sg(3)), 0, d2(E, E), 1,
             d4(B, sg(1), sg(2), sg(3)), 0, 1);
    @(negedge clk);
    data = 8'd123; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    data = 8'd77; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (44) @(negedge clk);

    // Reset mid-CONV: busy drops, display blank, ovf cleared
    push_exp(d4(B, B, B, B), 0, d2(B, B), 0, d4(B, B, B, B), 0, 0);
    @(negedge clk);
    data = 8'd55; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Normal conversion after the abort
    push_exp(d4(B, B, sg(4), sg(2)), 0, d2(sg(4), sg(2)), 0,
             d4(B, B, sg(4), sg(2)), 0, 1);
    send(8'd42);

    t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
